fir_mac_engine: RTL
===================

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 The block SHALL have no parameters; tap count is fixed at 4 and the accumulator width at 18 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  one-cycle strobe; x0..x3 are valid this cycle.
REQ-005 x0, x1, x2, x3  input  8 each  unsigned taps from the delay line: x[n], x[n-1], x[n-2], x[n-3].
REQ-006 coef_we  input  1  coefficient write enable.
REQ-007 coef_addr  input  2  coefficient index 0..3.
REQ-008 coef_data  input  8  signed two's-complement coefficient.
REQ-009 overrun_clr  input  1  clears the sticky overrun flag.
REQ-010 y_out  output  18  signed result, sum of x_i*c_i for i = 0..3.
REQ-011 y_valid  output  1  one-cycle pulse; y_out is new this cycle.
REQ-012 busy  output  1  high while a computation is in progress (state MAC).
REQ-013 overrun  output  1  sticky flag; a start arrived while busy.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and MAC, and a 2-bit tap counter.
REQ-015 Coefficient writes: on an edge with coef_we=1, coef[coef_addr] SHALL be loaded with coef_data, in any state.
REQ-016 IDLE + start SHALL do the following on the same edge:
- snapshot x0..x3 and coef[0..3] into working registers
- clear the accumulator and set the tap counter to 0
- enter MAC
REQ-017 On a start edge that coincides with a coef_we, the snapshot SHALL take the pre-write coefficient value; the write still lands in the coefficient bank.
REQ-018 Each MAC edge SHALL add the product of snapshot tap k and snapshot coef k to the accumulator, then increment k.
REQ-019 Products SHALL be the zero-extended 9-bit signed tap times the 8-bit signed coefficient; sums SHALL be sign-extended to 18 bits with no saturation or wrap (full range fits).
REQ-020 The k=3 MAC edge SHALL do the following:
- load y_out with the final sum
- assert y_valid for exactly one cycle
- return the FSM to IDLE
REQ-021 Latency: start sampled at edge E0 SHALL give y_valid high in the cycle after edge E4, i.e. 4 cycles after the start edge.
REQ-022 busy SHALL be combinational (state == MAC).
REQ-023 A start on the edge immediately after E4 (the cycle in which y_valid is high) SHALL be accepted; maximum throughput is one result per 5 cycles.
REQ-024 A start sampled while in MAC, including the k=3 edge, SHALL be ignored and SHALL set overrun; the current computation continues unchanged.
REQ-025 overrun_clr SHALL clear overrun; if overrun_clr and an overrun-setting start occur on the same edge, overrun SHALL end set.
REQ-026 y_out SHALL hold its value until the next completion.
REQ-027 Coefficient writes during MAC SHALL NOT affect the in-flight result.

Reset
REQ-028 rst=1 SHALL force the following on the next edge, overriding every other input:
- FSM to IDLE and the tap counter to 0
- accumulator, y_out, all four coefficients and all snapshots to 0
- y_valid and overrun to 0
REQ-029 rst asserted during MAC SHALL abort the computation; no y_valid pulse SHALL follow from the aborted start.
REQ-030 The first start accepted after reset deassertion SHALL behave exactly as in REQ-016.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- After reset, start with x0..x3={10,20,30,40} -> y_valid 4 cycles later, y_out=0; busy, overrun low throughout.
- coef={1,2,3,4}, x0..x3={1,2,3,4}, start -> y_valid exactly 4 cycles after the start edge, y_out=30.
- All coef=-128, all x=255 -> y_out=-130560 (18'h20200); all coef=127, all x=255 -> y_out=129540.
- Start accepted, second start 2 cycles later -> second start ignored, y_out matches first start only, overrun=1; overrun_clr -> overrun=0; back-to-back start in the y_valid cycle -> accepted, no overrun.
- coef={1,1,1,1}, x all 5, start, write coef[0]=100 one cycle later -> y_out=20; next start with the same x -> y_out=515.
- rst asserted 2 cycles after start -> no y_valid; y_out=0, busy=0, overrun=0, coefficients read back as 0 through the next computation (y_out=0).

Source files
------------

// File: rtl/fir_mac_if.sv
// Handshake and data bundle for the 4-tap FIR multiply-accumulate engine.
// The master drives taps, coefficients and strobes; the slave returns results.
interface fir_mac_if;
    logic        start;
    logic [7:0]  x0;
    logic [7:0]  x1;
    logic [7:0]  x2;
    logic [7:0]  x3;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        overrun_clr;
    logic [17:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        overrun;

    modport master (
        output start, x0, x1, x2, x3,
        output coef_we, coef_addr, coef_data, overrun_clr,
        input  y_out, y_valid, busy, overrun
    );

    modport slave (
        input  start, x0, x1, x2, x3,
        input  coef_we, coef_addr, coef_data, overrun_clr,
        output y_out, y_valid, busy, overrun
    );
endinterface

// File: rtl/fir_mac_engine.sv
// Sequential 4-tap FIR engine: one multiply-accumulate per cycle,
// result pulse 4 cycles after start, sticky overrun on ignored starts.
module fir_mac_engine (
    input  logic      clk,
    input  logic      rst,
    fir_mac_if.slave  bus
);
    typedef enum logic {IDLE, MAC} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          k;
    logic signed [17:0]  acc;
    logic signed [17:0]  acc_nxt;
    logic [17:0]         y_q;
    logic                yv_q;
    logic                ov_q;
    logic [7:0]          coef [4];
    logic [7:0]          xs [4];
    logic [7:0]          cs [4];
    logic signed [16:0]  tap_s;
    logic signed [16:0]  coef_s;
    logic signed [16:0]  prod;

    // Taps are unsigned, so zero-extend; coefficients are sign-extended.
    assign tap_s   = {9'b0, xs[k]};
    assign coef_s  = {{9{cs[k][7]}}, cs[k]};
    assign prod    = tap_s * coef_s;
    assign acc_nxt = acc + {prod[16], prod};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = MAC;
            MAC:     if (k == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k    <= '0;
            acc  <= '0;
            y_q  <= '0;
            yv_q <= 1'b0;
            ov_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                coef[i] <= '0;
                xs[i]   <= '0;
                cs[i]   <= '0;
            end
        end else begin
            yv_q <= 1'b0;
            // Snapshot below reads coef before this write lands.
            if (bus.coef_we) coef[bus.coef_addr] <= bus.coef_data;
            if (bus.start && state == MAC) ov_q <= 1'b1;
            else if (bus.overrun_clr)      ov_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    xs[0] <= bus.x0;
                    xs[1] <= bus.x1;
                    xs[2] <= bus.x2;
                    xs[3] <= bus.x3;
                    for (int i = 0; i < 4; i++) cs[i] <= coef[i];
                    acc <= '0;
                    k   <= '0;
                end
            end else begin
                acc <= acc_nxt;
                k   <= k + 2'd1;
                if (k == 2'd3) begin
                    y_q  <= acc_nxt;
                    yv_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy    = (state == MAC);
    assign bus.y_out   = y_q;
    assign bus.y_valid = yv_q;
    assign bus.overrun = ov_q;
endmodule
